sar_logic_param: RTL and testbench

Parametrised successive-approximation register (SAR) control logic for the SAR ADC macro. It generalises the fixed 10-bit monotonic SAR logic to any resolution and both switching modes. It generates the sampling pulse internally from a start request and drives the capacitive-DAC switch words `b`/`bn` one bit per clock. It also registers the final code with an end-of-conversion strobe and flags invalid comparator decisions. It sits between the comparator outputs and the DAC switch drivers, one instance per ADC channel.

---
 rtl/sar_logic_param.sv | 124 ++++++++++++
 tb/tb_sar_logic_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sar_logic_param.sv
// Parametrised SAR control logic: internal sample pulse, one DAC bit per clock,
// monotonic or trial-bit switching, registered result with eoc/data_valid strobes.
module sar_logic_param #(
  parameter int unsigned NBITS       = 10,
  parameter int unsigned SAMP_CYCLES = 2,
  parameter int unsigned MODE        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             comp,
  input  logic             comp_n,
  output logic             samp,
  output logic [NBITS-1:0] b,
  output logic [NBITS-1:0] bn,
  output logic [NBITS-1:0] data_out,
  output logic             data_valid,
  output logic             eoc,
  output logic             busy,
  output logic             comp_err
);

  localparam int unsigned KW = $clog2(NBITS);
  localparam int unsigned CW = (SAMP_CYCLES > 1) ? $clog2(SAMP_CYCLES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SAMPLE  = 2'd1;
  localparam logic [1:0] CONVERT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             samp_nxt, busy_nxt, eoc_nxt, data_valid_nxt, comp_err_nxt;
  logic [NBITS-1:0] b_nxt, bn_nxt, data_out_nxt;

  // Next-state and next-output decode
  always_comb begin
    state_nxt      = state;
    k_nxt          = k;
    cnt_nxt        = cnt;
    samp_nxt       = samp;
    busy_nxt       = busy;
    eoc_nxt        = 1'b0;
    data_valid_nxt = 1'b0;
    comp_err_nxt   = comp_err;
    b_nxt          = b;
    bn_nxt         = bn;
    data_out_nxt   = data_out;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt    = SAMPLE;
          samp_nxt     = 1'b1;
          busy_nxt     = 1'b1;
          b_nxt        = '0;
          bn_nxt       = '0;
          comp_err_nxt = 1'b0;
          cnt_nxt      = CW'(SAMP_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      SAMPLE: begin
        if (cnt == '0) begin
          state_nxt = CONVERT;
          samp_nxt  = 1'b0;
          k_nxt     = KW'(NBITS - 1);
          if (MODE == 1) b_nxt[NBITS-1] = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      CONVERT: begin
        // Capture from comp even when the comparator decision is ambiguous
        b_nxt[k]  = comp;
        bn_nxt[k] = comp_n;
        if (comp == comp_n) comp_err_nxt = 1'b1;
        if (MODE == 1 && k != '0) b_nxt[k - KW'(1)] = 1'b1;
        if (k == '0) begin
          state_nxt      = DONE;
          data_out_nxt   = b_nxt;
          data_valid_nxt = 1'b1;
          eoc_nxt        = 1'b1;
          busy_nxt       = 1'b0;
        end else begin
          k_nxt = k - KW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= KW'(NBITS - 1);
      cnt        <= '0;
      samp       <= 1'b0;
      busy       <= 1'b0;
      eoc        <= 1'b0;
      data_valid <= 1'b0;
      comp_err   <= 1'b0;
      b          <= '0;
      bn         <= '0;
      data_out   <= '0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      cnt        <= cnt_nxt;
      samp       <= samp_nxt;
      busy       <= busy_nxt;
      eoc        <= eoc_nxt;
      data_valid <= data_valid_nxt;
      comp_err   <= comp_err_nxt;
      b          <= b_nxt;
      bn         <= bn_nxt;
      data_out   <= data_out_nxt;
    end
  end

endmodule

// File: tb/tb_sar_logic_param.sv
// Directed bench for sar_logic_param: monotonic 10-bit/S=2 instance and
// trial-bit 4-bit/S=1 instance, with hand-computed expected codes.
module tb_sar_logic_param;

  localparam int S = 2;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst;
  logic start0, comp0, comp_n0;
  logic start1, comp1, comp_n1;

  logic         samp0, dv0, eoc0, busy0, err0;
  logic [9:0]   b0, bn0, dout0;
  logic         samp1, dv1, eoc1, busy1, err1;
  logic [3:0]   b1, bn1, dout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sar_logic_param #(.NBITS(10), .SAMP_CYCLES(2), .MODE(0)) u_mono (
    .clk(clk), .rst(rst), .start(start0), .comp(comp0), .comp_n(comp_n0),
    .samp(samp0), .b(b0), .bn(bn0), .data_out(dout0), .data_valid(dv0),
    .eoc(eoc0), .busy(busy0), .comp_err(err0)
  );

  sar_logic_param #(.NBITS(4), .SAMP_CYCLES(1), .MODE(1)) u_trial (
    .clk(clk), .rst(rst), .start(start1), .comp(comp1), .comp_n(comp_n1),
    .samp(samp1), .b(b1), .bn(bn1), .data_out(dout1), .data_valid(dv1),
    .eoc(eoc1), .busy(busy1), .comp_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One conversion on the monotonic instance; edge 0 samples start.
  // err_bit: bit driven with comp==comp_n==1; poke_edge: stray start; rst_edge: mid reset.
  task automatic run0(input logic [9:0] pat, input int err_bit, input int poke_edge,
                      input int rst_edge, input int last_edge);
    logic [9:0] exp_bn;
    bit         was_rst;
    int         j;
    exp_bn = ~pat;
    if (err_bit >= 0) exp_bn[err_bit] = 1'b1;
    was_rst = 1'b0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    check("start_samp", samp0, 1'b1);
    check("start_busy", busy0, 1'b1);
    check("start_b", b0, 10'h0);
    check("start_err", err0, 1'b0);
    for (int e = 1; e <= last_edge; e++) begin
      j = S + N - e;
      if (e >= S + 1 && e <= S + N) begin
        comp0   = pat[j];
        comp_n0 = (j == err_bit) ? pat[j] : ~pat[j];
      end else begin
        comp0   = 1'b0;
        comp_n0 = 1'b1;
      end
      start0 = (e == poke_edge);
      rst    = (e == rst_edge);
      step();
      start0 = 1'b0;
      rst    = 1'b0;
      if (e == rst_edge) begin
        was_rst = 1'b1;
        check("rst_samp", samp0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_b", b0, 10'h0);
        check("rst_bn", bn0, 10'h0);
        check("rst_dout", dout0, 10'h0);
        check("rst_err", err0, 1'b0);
      end
      if (was_rst) begin
        check("rst_no_eoc", eoc0, 1'b0);
      end else begin
        check("samp", samp0, e < S);
        check("eoc", eoc0, e == S + N);
        check("dv", dv0, e == S + N);
        check("busy", busy0, e < S + N);
        check("comp_err", err0, err_bit >= 0 && e >= S + N - err_bit);
        if (e == S + N) begin
          check("dout", dout0, pat);
          check("bn_final", bn0, exp_bn);
        end
        if (e == S + N + 1) check("b_hold", b0, pat);
      end
    end
  endtask

  initial begin
    logic [3:0] bexp [5];
    logic [3:0] cseq;
    int         j;
    bexp = '{4'h8, 4'h4, 4'h6, 4'h7, 4'h6};
    cseq = 4'b0110;
    rst = 1'b1;
    start0 = 1'b0; comp0 = 1'b0; comp_n0 = 1'b1;
    start1 = 1'b0; comp1 = 1'b0; comp_n1 = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_samp", samp0, 1'b0);
    check("reset_b", b0, 10'h0);
    check("reset_bn", bn0, 10'h0);
    check("reset_dout", dout0, 10'h0);
    check("reset_eoc", eoc0, 1'b0);
    check("reset_busy", busy0, 1'b0);
    check("reset_err", err0, 1'b0);
    check("reset_b1", b1, 4'h0);

    // Monotonic capture: alternating decisions give 2AA / 155
    run0(10'h2AA, -1, -1, -1, 14);

    // Trial-bit conversion on the 4-bit instance
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("t_samp", samp1, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      j = 5 - e;
      if (e >= 2) begin
        comp1   = cseq[j];
        comp_n1 = ~cseq[j];
      end
      step();
      check("t_b", b1, bexp[e-1]);
      check("t_eoc", eoc1, e == 5);
    end
    check("t_dout", dout1, 4'h6);
    check("t_bn", bn1, 4'h9);
    step();
    check("t_eoc_drop", eoc1, 1'b0);

    // Back-to-back with start held high: period S+N+1 = 13
    comp0 = 1'b1;
    comp_n0 = 1'b0;
    start0 = 1'b1;
    step();
    for (int e = 1; e <= 38; e++) begin
      step();
      check("bb_eoc", eoc0, e == 12 || e == 25 || e == 38);
      if (e == 12) check("bb_dout", dout0, 10'h3FF);
      if (e == 13 || e == 26) begin
        check("bb_samp", samp0, 1'b1);
        check("bb_b_clr", b0, 10'h0);
      end
    end
    start0 = 1'b0;
    step();
    step();
    check("bb_idle", busy0, 1'b0);

    // Stray start mid-CONVERT is ignored
    run0(10'h0F0, -1, 5, -1, 20);

    // Reset mid-conversion, then a normal conversion
    run0(10'h3FF, -1, -1, S + 3, 15);
    run0(10'h155, -1, -1, -1, 14);

    // Comparator error at bit 5, then cleared by the next conversion
    run0(10'h020, 5, -1, -1, 14);
    run0(10'h2AA, -1, -1, -1, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
